cdb_arbiter: RTL and testbench

// Shares the NUM_CDB common-data-bus write-back slots among NUM_REQ functional-unit result producers.
// - Each FU result is captured in a 1-entry per-FU holding buffer.
// - Up to NUM_CDB buffered results per cycle are granted, in round-robin order.
// - Granted results are driven, registered, onto the CDB that feeds the RS, register status table and ROB.

---
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Purpose: shares NUM_CDB result-broadcast slots among NUM_REQ FU producers through 1-entry per-FU buffers, round-robin.
// Latency: a result accepted at edge N is broadcast on the registered CDB after edge N+1 (no bypass).
// Backpressure: req_ready[i] = buffer empty or being granted; cdb_ready=0 or flush stalls grants so full FUs see req_ready=0.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = 2,
    parameter int VAL_W   = 32,
    parameter int ADDR_W  = 6,
    parameter int TAG_W   = 5,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][VAL_W-1:0]    req_val,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag,
    input  logic                             cdb_ready,
    output logic [NUM_CDB-1:0]               cdb_valid,
    output logic [NUM_CDB-1:0][ADDR_W-1:0]   cdb_addr,
    output logic [NUM_CDB-1:0][VAL_W-1:0]    cdb_val,
    output logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag,
    output logic [NUM_CDB-1:0][SRC_W-1:0]    cdb_src
);

    logic [NUM_REQ-1:0]               buf_v_q, buf_v_d;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [NUM_REQ-1:0][VAL_W-1:0]    buf_val_q, buf_val_d;
    logic [NUM_REQ-1:0][TAG_W-1:0]    buf_tag_q, buf_tag_d;
    logic [SRC_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [NUM_CDB-1:0]               cdb_valid_q, cdb_valid_d;
    logic [NUM_CDB-1:0][ADDR_W-1:0]   cdb_addr_q, cdb_addr_d;
    logic [NUM_CDB-1:0][VAL_W-1:0]    cdb_val_q, cdb_val_d;
    logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag_q, cdb_tag_d;
    logic [NUM_CDB-1:0][SRC_W-1:0]    cdb_src_q, cdb_src_d;

    // Scan results: which buffers win this cycle and which slot each one lands in
    logic [NUM_REQ-1:0]               grant;
    logic [NUM_CDB-1:0]               slot_vld;
    logic [NUM_CDB-1:0][SRC_W-1:0]    slot_src;
    logic [SRC_W-1:0]                 last_idx;
    logic [SRC_W:0]                   scan_sum;
    logic [SRC_W-1:0]                 scan_idx;
    int                               grant_cnt;

    // Walk buffers from rr_ptr with wrap, granting the first NUM_CDB occupied ones in scan order
    always_comb begin
        grant     = '0;
        slot_vld  = '0;
        slot_src  = '0;
        last_idx  = rr_ptr_q;
        scan_sum  = '0;
        scan_idx  = '0;
        grant_cnt = 0;
        if (cdb_ready && !flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
                if (scan_sum >= (SRC_W+1)'(NUM_REQ)) begin
                    scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
                end
                scan_idx = scan_sum[SRC_W-1:0];
                if (buf_v_q[scan_idx] && (grant_cnt < NUM_CDB)) begin
                    grant = grant | (NUM_REQ'(1) << scan_idx);
                    for (int j = 0; j < NUM_CDB; j++) begin
                        if (j == grant_cnt) begin
                            slot_vld[j] = 1'b1;
                            slot_src[j] = scan_idx;
                        end
                    end
                    last_idx  = scan_idx;
                    grant_cnt = grant_cnt + 1;
                end
            end
        end
    end

    // A granted buffer may be refilled in the same cycle; flush blocks all acceptance
    assign req_ready = flush ? '0 : (~buf_v_q | grant);

    // Next state: buffer capture/release, CDB slot loading, pointer advance past the last winner
    always_comb begin
        buf_v_d     = buf_v_q;
        buf_addr_d  = buf_addr_q;
        buf_val_d   = buf_val_q;
        buf_tag_d   = buf_tag_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = slot_vld;
        cdb_addr_d  = cdb_addr_q;
        cdb_val_d   = cdb_val_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush) begin
                buf_v_d[i] = 1'b0;
            end else if (req_valid[i] && req_ready[i]) begin
                buf_v_d[i]    = 1'b1;
                buf_addr_d[i] = req_addr[i];
                buf_val_d[i]  = req_val[i];
                buf_tag_d[i]  = req_tag[i];
            end else if (grant[i]) begin
                buf_v_d[i] = 1'b0;
            end
        end

        for (int j = 0; j < NUM_CDB; j++) begin
            if (slot_vld[j]) begin
                cdb_addr_d[j] = buf_addr_q[slot_src[j]];
                cdb_val_d[j]  = buf_val_q[slot_src[j]];
                cdb_tag_d[j]  = buf_tag_q[slot_src[j]];
                cdb_src_d[j]  = slot_src[j];
            end
        end

        if (flush) begin
            rr_ptr_d = '0;
        end else if (|grant) begin
            rr_ptr_d = (last_idx == SRC_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    // State registers; reset empties every buffer and the broadcast outputs immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_v_q     <= '0;
            buf_addr_q  <= '0;
            buf_val_q   <= '0;
            buf_tag_q   <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_addr_q  <= '0;
            cdb_val_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            buf_v_q     <= buf_v_d;
            buf_addr_q  <= buf_addr_d;
            buf_val_q   <= buf_val_d;
            buf_tag_q   <= buf_tag_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_addr_q  <= cdb_addr_d;
            cdb_val_q   <= cdb_val_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_addr  = cdb_addr_q;
    assign cdb_val   = cdb_val_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose: exercises cdb_arbiter with directed scenarios and random traffic against a queue-based arbitration model.
// Latency: model expects a broadcast one edge after the grant cycle, two edges after acceptance.
// Backpressure: model derives req_ready from its own buffer occupancy and grant list.
module tb_cdb_arbiter;
    localparam int NR = 4;
    localparam int NC = 2;
    localparam int VW = 32;
    localparam int AW = 6;
    localparam int TW = 5;
    localparam int SW = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    flush = 1'b0;
    logic                    cdb_ready = 1'b1;
    logic [NR-1:0]           req_valid = '0;
    logic [NR-1:0]           req_ready;
    logic [NR-1:0][AW-1:0]   req_addr = '0;
    logic [NR-1:0][VW-1:0]   req_val = '0;
    logic [NR-1:0][TW-1:0]   req_tag = '0;
    logic [NC-1:0]           cdb_valid;
    logic [NC-1:0][AW-1:0]   cdb_addr;
    logic [NC-1:0][VW-1:0]   cdb_val;
    logic [NC-1:0][TW-1:0]   cdb_tag;
    logic [NC-1:0][SW-1:0]   cdb_src;

    cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC), .VAL_W(VW), .ADDR_W(AW), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_val(req_val), .req_tag(req_tag),
        .cdb_ready(cdb_ready), .cdb_valid(cdb_valid),
        .cdb_addr(cdb_addr), .cdb_val(cdb_val), .cdb_tag(cdb_tag), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    // Model: per-FU holding slots, a round-robin start index, and the last broadcast
    bit              m_bv[NR];
    logic [AW-1:0]   m_addr[NR];
    logic [VW-1:0]   m_val[NR];
    logic [TW-1:0]   m_tag[NR];
    int              m_rr;
    bit              e_vld[NC];
    logic [AW-1:0]   e_addr[NC];
    logic [VW-1:0]   e_val[NC];
    logic [TW-1:0]   e_tag[NC];
    int              e_src[NC];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < NR; i++) begin
            m_bv[i] = 1'b0; m_addr[i] = '0; m_val[i] = '0; m_tag[i] = '0;
        end
        for (int j = 0; j < NC; j++) begin
            e_vld[j] = 1'b0; e_addr[j] = '0; e_val[j] = '0; e_tag[j] = '0; e_src[j] = 0;
        end
    endtask

    // Drive one cycle's inputs (called at negedge) with fresh random payloads
    task automatic drive(input logic [NR-1:0] v, input bit rdy, input bit fl);
        req_valid = v;
        cdb_ready = rdy;
        flush     = fl;
        for (int i = 0; i < NR; i++) begin
            req_addr[i] = AW'($urandom);
            req_val[i]  = $urandom;
            req_tag[i]  = TW'($urandom);
        end
    endtask

    // One clock: check req_ready before the edge, advance the model at the edge, check the CDB after it
    task automatic cycle();
        int gl[$];
        bit gr[NR];
        bit rdy[NR];
        #1;
        for (int i = 0; i < NR; i++) gr[i] = 1'b0;
        if (cdb_ready && !flush) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_rr + k) % NR;
                if (m_bv[idx] && gl.size() < NC) begin
                    gl.push_back(idx);
                    gr[idx] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            rdy[i] = !flush && (!m_bv[i] || gr[i]);
            check($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(rdy[i]));
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < NC; j++) begin
            if (j < gl.size()) begin
                e_vld[j]  = 1'b1;
                e_addr[j] = m_addr[gl[j]];
                e_val[j]  = m_val[gl[j]];
                e_tag[j]  = m_tag[gl[j]];
                e_src[j]  = gl[j];
            end else begin
                e_vld[j] = 1'b0;
            end
        end
        if (flush) begin
            for (int i = 0; i < NR; i++) m_bv[i] = 1'b0;
            m_rr = 0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    m_bv[i] = 1'b1; m_addr[i] = req_addr[i]; m_val[i] = req_val[i]; m_tag[i] = req_tag[i];
                end else if (gr[i]) begin
                    m_bv[i] = 1'b0;
                end
            end
            if (gl.size() > 0) m_rr = (gl[gl.size()-1] + 1) % NR;
        end
        for (int j = 0; j < NC; j++) begin
            check($sformatf("cdb_valid[%0d]", j), 64'(cdb_valid[j]), 64'(e_vld[j]));
            check($sformatf("cdb_addr[%0d]", j), 64'(cdb_addr[j]), 64'(e_addr[j]));
            check($sformatf("cdb_val[%0d]", j), 64'(cdb_val[j]), 64'(e_val[j]));
            check($sformatf("cdb_tag[%0d]", j), 64'(cdb_tag[j]), 64'(e_tag[j]));
            check($sformatf("cdb_src[%0d]", j), 64'(cdb_src[j]), 64'(e_src[j]));
        end
        @(negedge clk);
    endtask

    // Assert reset across one rising edge; entered and left at a negedge
    task automatic do_reset();
        reset = 1'b0; req_valid = '0; flush = 1'b0; cdb_ready = 1'b1;
        #1;
        model_reset();
        check("reset_cdb_valid", 64'(cdb_valid), 64'h0);
        check("reset_cdb_addr", 64'(cdb_addr), 64'h0);
        check("reset_req_ready", 64'(req_ready), 64'hF);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Single result from FU0: broadcast on slot 0 two edges after acceptance
        do_reset();
        drive(4'b0001, 1'b1, 1'b0);
        req_val[0] = 32'h1234; req_addr[0] = 6'd5; req_tag[0] = 5'd3;
        check("t1_ready", 64'(req_ready[0]), 64'h1);
        cycle();
        drive(4'b0000, 1'b1, 1'b0);
        cycle();
        check("t1_valid", 64'(cdb_valid), 64'h1);
        check("t1_addr", 64'(cdb_addr[0]), 64'h5);
        check("t1_val", 64'(cdb_val[0]), 64'h1234);
        check("t1_tag", 64'(cdb_tag[0]), 64'h3);
        check("t1_src", 64'(cdb_src[0]), 64'h0);

        // All FUs always valid: grant pairs alternate {0,1},{2,3},{0,1}
        do_reset();
        drive(4'hF, 1'b1, 1'b0); cycle();
        drive(4'hF, 1'b1, 1'b0); cycle();
        check("t2_src_a", {62'h0, cdb_src[1], cdb_src[0]}, 64'h4);
        check("t2_ready_a", 64'(req_ready), 64'hC);
        drive(4'hF, 1'b1, 1'b0); cycle();
        check("t2_src_b", {62'h0, cdb_src[1], cdb_src[0]}, 64'hE);
        check("t2_ready_b", 64'(req_ready), 64'h3);
        drive(4'hF, 1'b1, 1'b0); cycle();
        check("t2_src_c", {62'h0, cdb_src[1], cdb_src[0]}, 64'h4);

        // Wrap-around: pointer at 3 with FU3 and FU0 buffered
        do_reset();
        drive(4'b0100, 1'b1, 1'b0); cycle();
        drive(4'b1001, 1'b1, 1'b0); cycle();
        check("t3_first", 64'(cdb_src[0]), 64'h2);
        drive(4'b0000, 1'b1, 1'b0); cycle();
        check("t3_valid", 64'(cdb_valid), 64'h3);
        check("t3_src0", 64'(cdb_src[0]), 64'h3);
        check("t3_src1", 64'(cdb_src[1]), 64'h0);
        drive(4'b0111, 1'b1, 1'b0); cycle();
        drive(4'b0000, 1'b1, 1'b0); cycle();
        check("t3_after_wrap", {62'h0, cdb_src[1], cdb_src[0]}, 64'h9);

        // Consumer stall for 5 cycles with every FU pushing, then drain
        do_reset();
        drive(4'hF, 1'b1, 1'b0); cycle();
        for (int s = 0; s < 5; s++) begin
            drive(4'hF, 1'b0, 1'b0); cycle();
            if (s == 0) begin
                check("t4_stall_valid", 64'(cdb_valid), 64'h0);
                check("t4_stall_ready", 64'(req_ready), 64'h0);
            end
        end
        drive(4'h0, 1'b1, 1'b0); cycle();
        check("t4_drain_a", {60'h0, cdb_valid, cdb_src[1], cdb_src[0]}, 64'h34);
        drive(4'h0, 1'b1, 1'b0); cycle();
        check("t4_drain_b", {60'h0, cdb_valid, cdb_src[1], cdb_src[0]}, 64'h3E);
        drive(4'h0, 1'b1, 1'b0); cycle();
        check("t4_drain_end", 64'(cdb_valid), 64'h0);

        // Flush with three buffers full and both slots live
        do_reset();
        drive(4'b0111, 1'b1, 1'b0); cycle();
        drive(4'b0011, 1'b1, 1'b0); cycle();
        check("t5_pre_valid", 64'(cdb_valid), 64'h3);
        drive(4'hF, 1'b1, 1'b1); cycle();
        check("t5_flush_valid", 64'(cdb_valid), 64'h0);
        drive(4'h0, 1'b1, 1'b0);
        #1;
        check("t5_flush_ready", 64'(req_ready), 64'hF);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            drive(4'h0, 1'b1, 1'b0); cycle();
        end
        check("t5_no_squashed", 64'(cdb_valid), 64'h0);

        // Asynchronous reset pulse mid-traffic, between clock edges
        do_reset();
        for (int s = 0; s < 3; s++) begin
            drive(4'hF, 1'b1, 1'b0); cycle();
        end
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_valid", 64'(cdb_valid), 64'h0);
        check("t6_async_ready", 64'(req_ready), 64'hF);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        drive(4'hF, 1'b1, 1'b0); cycle();
        drive(4'h0, 1'b1, 1'b0); cycle();
        check("t6_restart", {60'h0, cdb_valid, cdb_src[1], cdb_src[0]}, 64'h34);

        // Random traffic with occasional stalls and flushes
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(NR'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
